// File: rtl/aes_in_serializer.sv
// Serializes one 128-bit key + plaintext pair into 16 byte-pair FIFO words, MSB first.
// Word 15 carries LAST_FLAG in [31:16] so the AES core knows the block is complete.
module aes_in_serializer #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [15:0] LAST_FLAG  = 16'h1111
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    input  logic [127:0]          blk_key,
    input  logic [127:0]          blk_data,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  busy,
    output logic [15:0]           blk_count
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state;
    logic [3:0]    idx;
    logic [127:0]  key_sr;
    logic [127:0]  data_sr;
    logic [15:0]   count_q;
    logic          last_word;
    logic          accept;

    assign last_word = (idx == 4'd15);
    assign fifo_wr   = (state == SEND) && !fifo_full;
    // Ready on the final word lets the next block follow with no bubble.
    assign blk_ready = !reset && ((state == IDLE) || (last_word && !fifo_full));
    assign accept    = blk_valid && blk_ready;
    assign busy      = (state == SEND);
    assign blk_count = count_q;

    always_comb begin
        fifo_dout = '0;
        if (state == SEND) begin
            fifo_dout[7:0]  = data_sr[127:120];
            fifo_dout[15:8] = key_sr[127:120];
            if (last_word) begin
                fifo_dout[31:16] = LAST_FLAG;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 4'd0;
            key_sr  <= '0;
            data_sr <= '0;
            count_q <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        key_sr  <= blk_key;
                        data_sr <= blk_data;
                        idx     <= 4'd0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (!fifo_full) begin
                        if (last_word) begin
                            count_q <= count_q + 16'd1;
                            idx     <= 4'd0;
                            if (accept) begin
                                key_sr  <= blk_key;
                                data_sr <= blk_data;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            key_sr  <= {key_sr[119:0], 8'h00};
                            data_sr <= {data_sr[119:0], 8'h00};
                            idx     <= idx + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_in_serializer.sv
// Scoreboard bench for aes_in_serializer: stimulus pushes expected FIFO words,
// a negedge monitor pops and compares every word the DUT writes.
module tb_aes_in_serializer;

    logic         clock = 1'b0;
    logic         reset;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_key;
    logic [127:0] blk_data;
    logic         fifo_full;
    logic         fifo_wr;
    logic [31:0]  fifo_dout;
    logic         busy;
    logic [15:0]  blk_count;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];

    localparam logic [127:0] KEY_A  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] DATA_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = {16{8'hAA}};
    localparam logic [127:0] DATA_B = {16{8'h55}};

    aes_in_serializer #(.DATA_WIDTH(32), .LAST_FLAG(16'h1111)) dut (
        .clock     (clock),
        .reset     (reset),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_key   (blk_key),
        .blk_data  (blk_data),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_dout (fifo_dout),
        .busy      (busy),
        .blk_count (blk_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [127:0] k, input logic [127:0] d, input int i);
        logic [31:0] w;
        w        = '0;
        w[15:8]  = k[127-8*i -: 8];
        w[7:0]   = d[127-8*i -: 8];
        if (i == 15) w[31:16] = 16'h1111;
        return w;
    endfunction

    // Monitor: every write the DUT makes must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && fifo_wr) begin
            writes++;
            if (exp_q.size() == 0) begin
                check_value("unexpected_write", fifo_dout, 32'hxxxxxxxx);
            end else begin
                check_value("fifo_word", fifo_dout, exp_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Issues a block, returning one time unit after the accepting edge.
    task automatic send_block(input logic [127:0] k, input logic [127:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        blk_key   = k;
        blk_data  = d;
        blk_valid = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(model_word(k, d, i));
        while (!acc && n < 100) begin
            @(negedge clock);
            acc = blk_ready;
            @(posedge clock);
            #1;
            n++;
        end
        if (!acc) check_value("accept_timeout", 32'(acc), 32'd1);
        blk_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            cycles(1);
            n++;
        end
        if (busy) check_value("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic applyStimulus();
        int w0;
        int c0;

        // Reset state, checked while reset is held and just after release.
        reset = 1'b1; blk_valid = 1'b0; fifo_full = 1'b0;
        blk_key = '0; blk_data = '0;
        #2;
        check_value("ready_in_reset", 32'(blk_ready), 32'd0);
        check_value("wr_in_reset", 32'(fifo_wr), 32'd0);
        cycles(2);
        reset = 1'b0;
        #1;
        check_value("ready_after_reset", 32'(blk_ready), 32'd1);
        check_value("busy_after_reset", 32'(busy), 32'd0);
        check_value("dout_after_reset", fifo_dout, 32'd0);
        check_value("count_after_reset", 32'(blk_count), 32'd0);
        cycles(1);

        // Single block, no stalls.
        w0 = writes;
        send_block(KEY_A, DATA_A);
        check_value("busy_on_accept", 32'(busy), 32'd1);
        check_value("wr_word0", 32'(fifo_wr), 32'd1);
        check_value("dout_word0", fifo_dout, 32'h00000000);
        check_value("ready_word0", 32'(blk_ready), 32'd0);
        cycles(15);
        check_value("busy_word15", 32'(busy), 32'd1);
        check_value("dout_word15", fifo_dout, 32'h11110fff);
        check_value("ready_word15", 32'(blk_ready), 32'd1);
        cycles(1);
        check_value("busy_fall", 32'(busy), 32'd0);
        check_value("count_1", 32'(blk_count), 32'd1);
        check_value("writes_single", 32'(writes - w0), 32'd16);

        // Three-cycle stall at word 5.
        send_block(KEY_A, DATA_A);
        cycles(5);
        w0 = writes;
        fifo_full = 1'b1;
        #1;
        check_value("wr_stalled", 32'(fifo_wr), 32'd0);
        cycles(3);
        check_value("dout_held", fifo_dout, 32'h00000555);
        check_value("writes_stall", 32'(writes - w0), 32'd0);
        fifo_full = 1'b0;
        cycles(10);
        check_value("busy_stall_end", 32'(busy), 32'd1);
        cycles(1);
        check_value("busy_after_stall", 32'(busy), 32'd0);
        check_value("count_2", 32'(blk_count), 32'd2);

        // Back-to-back blocks with no bubble.
        w0 = writes;
        send_block(KEY_A, DATA_A);
        send_block(KEY_B, DATA_B);
        check_value("count_b2b_mid", 32'(blk_count), 32'd3);
        check_value("dout_b2b_word0", fifo_dout, 32'h0000AA55);
        cycles(15);
        check_value("busy_b2b", 32'(busy), 32'd1);
        check_value("dout_b2b_last", fifo_dout, 32'h1111AA55);
        cycles(1);
        check_value("busy_b2b_end", 32'(busy), 32'd0);
        check_value("writes_b2b", 32'(writes - w0), 32'd32);
        check_value("count_4", 32'(blk_count), 32'd4);

        // Full at the last word blocks the next accept.
        send_block(KEY_A, DATA_A);
        cycles(15);
        fifo_full = 1'b1;
        blk_key = KEY_B; blk_data = DATA_B; blk_valid = 1'b1;
        #1;
        check_value("ready_full_last", 32'(blk_ready), 32'd0);
        check_value("wr_full_last", 32'(fifo_wr), 32'd0);
        cycles(2);
        check_value("busy_full_last", 32'(busy), 32'd1);
        check_value("ready_full_hold", 32'(blk_ready), 32'd0);
        fifo_full = 1'b0;
        blk_valid = 1'b0;
        cycles(1);
        check_value("idle_after_last", 32'(busy), 32'd0);
        check_value("ready_idle", 32'(blk_ready), 32'd1);
        c0 = cyc;
        send_block(KEY_B, DATA_B);
        check_value("accept_next_cycle", 32'(cyc - c0), 32'd1);
        wait_idle();
        check_value("count_6", 32'(blk_count), 32'd6);

        // Asynchronous reset after seven writes.
        send_block(KEY_A, DATA_A);
        w0 = writes - 7;
        cycles(7);
        reset = 1'b1;
        #1;
        check_value("wr_async_reset", 32'(fifo_wr), 32'd0);
        check_value("busy_async_reset", 32'(busy), 32'd0);
        check_value("dout_async_reset", fifo_dout, 32'd0);
        check_value("count_async_reset", 32'(blk_count), 32'd0);
        check_value("writes_before_reset", 32'(writes - w0 - 7), 32'd7);
        exp_q.delete();
        #2;
        reset = 1'b0;
        cycles(1);
        send_block(KEY_A, DATA_A);
        check_value("dout_restart", fifo_dout, 32'h00000000);
        wait_idle();
        check_value("count_restart", 32'(blk_count), 32'd1);

        // Counter wrap from 16'hFFFF.
        force dut.count_q = 16'hFFFF;
        cycles(1);
        release dut.count_q;
        #1;
        check_value("count_preset", 32'(blk_count), 32'h0000FFFF);
        send_block(KEY_B, DATA_B);
        wait_idle();
        check_value("count_wrap", 32'(blk_count), 32'd0);
        cycles(2);
    endtask

    task automatic checkOutput();
        check_value("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
    endtask

    initial begin
        applyStimulus();
        checkOutput();
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
